config_frame_writer: RTL and testbench
======================================

Name: config_frame_writer

Overview:
- Configuration-side driver of the tile frame interface. Turns a 32-bit bitstream word stream into row-parallel FrameData plus a one-hot FrameStrobe pulse.
- Sits between the bitstream source (UART/SPI loader) and the fabric's FrameData/FrameStrobe distribution nets, which tiles buffer and daisy-chain.
- Writes exactly one frame (one column, one frame index, all rows) per packet, with guaranteed data setup and hold around the strobe.

Parameters:
- FrameBitsPerRow, 32, width of FrameData per fabric row; bitstream word width.
- MaxFramesPerCol, 20, strobe lines per column.
- NumRows, 16, fabric rows; data words per packet.
- NumCols, 10, fabric columns.

Ports:
- UserCLK  input  1  clock.
- reset  input  1  reset; asynchronous, active-high.
- word_i  input  FrameBitsPerRow  bitstream word.
- word_valid_i  input  1  word_i valid.
- word_ready_o  output  1  word accepted when valid&&ready.
- FrameData  output  NumRows*FrameBitsPerRow  row r occupies bits [r*32+31:r*32].
- FrameStrobe  output  NumCols*MaxFramesPerCol  column c occupies [c*MaxFramesPerCol +: MaxFramesPerCol].
- busy_o  output  1  high in any state except IDLE.
- err_o  output  1  sticky error; cleared only by reset.
- frames_written_o  output  16  count of strobes issued; wraps at 0xFFFF->0.

Behaviour:
- Reset (async assert; deassert synchronous to UserCLK):
  - FrameData=0, FrameStrobe=0, err_o=0, frames_written_o=0, state=IDLE.
  - Reset mid-packet aborts the packet with no strobe.
- Packet = header word, then NumRows data words (row 0 first), then one checksum word if the optional feature is enabled.
- Header fields: [31:24]=8'hFA marker, [23:16]=column, [15:8]=frame, [7:0] ignored.
- States: IDLE, DATA, CHK (optional), SETUP, STROBE, HOLD.
- IDLE:
  - word_ready_o=1.
  - Accepted word with marker≠8'hFA: dropped, err_o set, stay IDLE.
  - Valid marker: latch column/frame, row counter=0, go to DATA.
  - Column≥NumCols or frame≥MaxFramesPerCol: err_o set and packet marked invalid; its data is still consumed.
- DATA:
  - word_ready_o=1.
  - Each accepted word goes to a shadow row register [row]; row counter increments.
  - After the word for row NumRows-1: go to CHK if enabled, else SETUP.
  - word_valid_i low stalls indefinitely; no timeout.
- SETUP (1 cycle): word_ready_o=0; shadow copied to FrameData. FrameData never changes while DATA is collecting.
- STROBE (1 cycle):
  - Valid packet: FrameStrobe bit column*MaxFramesPerCol+frame =1, all other bits 0; frames_written_o increments on this cycle.
  - Invalid packet: FrameStrobe stays 0, counter unchanged.
- HOLD (1 cycle): FrameStrobe=0, FrameData unchanged; then IDLE.
- FrameData holds its last value in IDLE; it is not cleared.
- Timing:
  - Strobe rises 2 cycles after acceptance of the last data word (3 with checksum).
  - Minimum packet period = NumRows+4 cycles (+1 with checksum).
- FrameStrobe is registered, glitch-free and one-hot-or-zero at all times.
- word_ready_o is combinational from state only, never from word_valid_i.

Optional Feature:
- Macro: CFG_FRAME_CHECKSUM_EN.
- With macro:
  - CHK state accepts one extra word and compares it with the running XOR of all NumRows data words.
  - Mismatch: err_o set, packet treated as invalid (SETUP/STROBE/HOLD sequence still runs but no strobe bit is set).
- Without macro: no CHK state; DATA goes directly to SETUP; checksum logic is absent.

Decomposition:
- Package cfg_frame_pkg:
  - state enum.
  - HDR_MARKER=8'hFA.
  - header field bit positions.
  - strobe index function (col*MaxFramesPerCol+frame).
- One sub-module, cfg_strobe_decoder: registered one-hot decoder from {column, frame, fire} to the FrameStrobe vector, with fire qualified by the valid flag.

Test Plan:
- Single frame: header 32'hFA020300, 16 words 32'h1000_0000+r -> FrameStrobe bit 43 high for exactly one cycle; row r of FrameData = 32'h1000_0000+r in the SETUP, STROBE and HOLD cycles; frames_written_o=1.
- Bad marker: word 32'h12345678 in IDLE -> dropped, err_o=1, FrameStrobe never asserted, next valid packet still writes.
- Out of range: header column=10 -> all 16 data words consumed, no strobe, err_o=1, frames_written_o unchanged.
- Backpressure/stall: word_valid_i toggled randomly during DATA -> same FrameData and strobe result as the back-to-back case; FrameData does not change before SETUP.
- Reset mid-packet: reset asserted after 7 data words -> outputs 0 immediately (asynchronously); next full packet writes correctly.
- CFG_FRAME_CHECKSUM_EN: correct XOR trailer -> strobe issued; trailer XOR^1 -> no strobe, err_o=1.

Source files
------------

// File: rtl/cfg_frame_pkg.sv
// Shared types and helpers for the configuration frame writer.
// Checksum trailer support is enabled by defining CFG_FRAME_CHECKSUM_EN.
package cfg_frame_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_CHK,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_t;

    localparam logic [7:0] HDR_MARKER = 8'hFA;

    localparam int HDR_MARK_LSB = 24;
    localparam int HDR_COL_LSB  = 16;
    localparam int HDR_FRM_LSB  = 8;

    function automatic int strobe_index(
        input int col,
        input int frame,
        input int frames_per_col
    );
        return col * frames_per_col + frame;
    endfunction

endpackage

// File: rtl/cfg_strobe_decoder.sv
// Registered one-hot decoder from {column, frame, fire} to FrameStrobe.
// Output is all-zero unless fire and valid are both high for a cycle.
module cfg_strobe_decoder
    import cfg_frame_pkg::*;
#(
    parameter int NumCols         = 10,
    parameter int MaxFramesPerCol = 20
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [7:0]                         col,
    input  logic [7:0]                         frame,
    input  logic                               fire,
    input  logic                               valid,
    output logic [NumCols*MaxFramesPerCol-1:0] strobe
);

    localparam int N  = NumCols * MaxFramesPerCol;
    localparam int IW = $clog2(N);

    logic [IW-1:0] idx;

    assign idx = IW'(strobe_index(int'(col), int'(frame), MaxFramesPerCol));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe <= '0;
        end else begin
            strobe <= '0;
            if (fire && valid) begin
                strobe[idx] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/config_frame_writer.sv
// Bitstream word stream to FrameData/FrameStrobe frame writer.
// Optional checksum trailer word: define CFG_FRAME_CHECKSUM_EN.
module config_frame_writer
    import cfg_frame_pkg::*;
#(
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int NumRows         = 16,
    parameter int NumCols         = 10
) (
    input  logic                                UserCLK,
    input  logic                                reset,
    input  logic [FrameBitsPerRow-1:0]          word_i,
    input  logic                                word_valid_i,
    output logic                                word_ready_o,
    output logic [NumRows*FrameBitsPerRow-1:0]  FrameData,
    output logic [NumCols*MaxFramesPerCol-1:0]  FrameStrobe,
    output logic                                busy_o,
    output logic                                err_o,
    output logic [15:0]                         frames_written_o
);

    localparam int RW = $clog2(NumRows);
    localparam logic [RW-1:0] LAST_ROW = RW'(NumRows - 1);

    typedef logic [NumRows-1:0][FrameBitsPerRow-1:0] rows_t;

    state_t        state;
    logic [RW-1:0] row;
    logic [7:0]    col_q;
    logic [7:0]    frm_q;
    logic          pkt_ok;
    rows_t         shadow;
    rows_t         shadow_nxt;
    rows_t         frame_q;
    logic          accept;
    logic          fire;
    logic [7:0]    hdr_mark;
    logic [7:0]    hdr_col;
    logic [7:0]    hdr_frm;
`ifdef CFG_FRAME_CHECKSUM_EN
    logic [FrameBitsPerRow-1:0] chk_acc;
`endif

    assign word_ready_o = (state == S_IDLE) || (state == S_DATA) ||
                          (state == S_CHK);
    assign busy_o       = (state != S_IDLE);
    assign accept       = word_valid_i && word_ready_o;
    assign fire         = (state == S_SETUP);
    assign FrameData    = frame_q;

    assign hdr_mark = word_i[HDR_MARK_LSB +: 8];
    assign hdr_col  = word_i[HDR_COL_LSB +: 8];
    assign hdr_frm  = word_i[HDR_FRM_LSB +: 8];

    // Shadow including the word being accepted, so the last row can go
    // straight into FrameData on the DATA->SETUP edge.
    always_comb begin
        shadow_nxt = shadow;
        if (state == S_DATA && accept) begin
            shadow_nxt[row] = word_i;
        end
    end

    always_ff @(posedge UserCLK or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            row              <= '0;
            col_q            <= '0;
            frm_q            <= '0;
            pkt_ok           <= 1'b0;
            shadow           <= '0;
            frame_q          <= '0;
            err_o            <= 1'b0;
            frames_written_o <= '0;
`ifdef CFG_FRAME_CHECKSUM_EN
            chk_acc          <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (hdr_mark != HDR_MARKER) begin
                            err_o <= 1'b1;
                        end else begin
                            col_q <= hdr_col;
                            frm_q <= hdr_frm;
                            row   <= '0;
                            state <= S_DATA;
`ifdef CFG_FRAME_CHECKSUM_EN
                            chk_acc <= '0;
`endif
                            if (int'(hdr_col) >= NumCols ||
                                int'(hdr_frm) >= MaxFramesPerCol) begin
                                pkt_ok <= 1'b0;
                                err_o  <= 1'b1;
                            end else begin
                                pkt_ok <= 1'b1;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        shadow <= shadow_nxt;
                        row    <= row + 1'b1;
`ifdef CFG_FRAME_CHECKSUM_EN
                        chk_acc <= chk_acc ^ word_i;
                        if (row == LAST_ROW) begin
                            state <= S_CHK;
                        end
`else
                        if (row == LAST_ROW) begin
                            frame_q <= shadow_nxt;
                            state   <= S_SETUP;
                        end
`endif
                    end
                end
`ifdef CFG_FRAME_CHECKSUM_EN
                S_CHK: begin
                    if (accept) begin
                        if (word_i != chk_acc) begin
                            err_o  <= 1'b1;
                            pkt_ok <= 1'b0;
                        end
                        frame_q <= shadow;
                        state   <= S_SETUP;
                    end
                end
`endif
                S_SETUP: begin
                    if (pkt_ok) begin
                        frames_written_o <= frames_written_o + 16'd1;
                    end
                    state <= S_STROBE;
                end
                S_STROBE: state <= S_HOLD;
                S_HOLD:   state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    cfg_strobe_decoder #(
        .NumCols         (NumCols),
        .MaxFramesPerCol (MaxFramesPerCol)
    ) u_dec (
        .clk    (UserCLK),
        .rst    (reset),
        .col    (col_q),
        .frame  (frm_q),
        .fire   (fire),
        .valid  (pkt_ok),
        .strobe (FrameStrobe)
    );

endmodule

// File: tb/tb_config_frame_writer.sv
// Directed plus randomized bench for config_frame_writer against a
// packet-level reference model.
module tb_config_frame_writer;

    localparam int W  = 32;
    localparam int NR = 16;
    localparam int NC = 10;
    localparam int MF = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic [W-1:0]      word;
    logic              valid;
    logic              ready;
    logic [NR*W-1:0]   fd;
    logic [NC*MF-1:0]  fs;
    logic              busy;
    logic              err;
    logic [15:0]       fw;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    logic [NR*W-1:0]   exp_fd;
    logic              exp_err;
    logic [15:0]       exp_cnt;
    int                exp_pulses;

    config_frame_writer dut (
        .UserCLK          (clk),
        .reset            (rst),
        .word_i           (word),
        .word_valid_i     (valid),
        .word_ready_o     (ready),
        .FrameData        (fd),
        .FrameStrobe      (fs),
        .busy_o           (busy),
        .err_o            (err),
        .frames_written_o (fw)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs,
                         input logic [511:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && fs != '0) begin
            pulses++;
            check("strobe_onehot", 512'($countones(fs)), 512'd1);
        end
    end

    // Starts and ends 1 time unit after a rising edge.
    task automatic send_word(input logic [W-1:0] w, input bit stall);
        int  n = 0;
        bit  took = 1'b0;
        if (stall) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        word  = w;
        valid = 1'b1;
        while (!took && n < 200) begin
            @(negedge clk);
            took = ready;
            @(posedge clk);
            #1;
            n++;
        end
        valid = 1'b0;
        word  = $urandom;
        if (!took) check("handshake_timeout", 512'd0, 512'd1);
    endtask

    task automatic send_packet(input logic [7:0] col, input logic [7:0] frm,
                               input bit det, input bit stall,
                               input bit bad_chk);
        logic [W-1:0]    d [NR];
        logic [W-1:0]    x;
        logic [NR*W-1:0] nfd;
        logic [NC*MF-1:0] efs;
        bit              ok;
        x   = '0;
        nfd = '0;
        efs = '0;
        send_word({8'hFA, col, frm, 8'($urandom)}, stall);
        for (int r = 0; r < NR; r++) begin
            d[r] = det ? (32'h1000_0000 + W'(r)) : W'($urandom);
            x ^= d[r];
            nfd[r*W +: W] = d[r];
            send_word(d[r], stall);
            if (r == NR - 2) check("fd_stable_in_data", fd, exp_fd);
        end
`ifdef CFG_FRAME_CHECKSUM_EN
        send_word(x ^ W'(bad_chk), stall);
        ok = (col < NC) && (frm < MF) && !bad_chk;
`else
        ok = (col < NC) && (frm < MF);
`endif
        exp_fd = nfd;
        if (ok) begin
            efs[int'(col) * MF + int'(frm)] = 1'b1;
            exp_cnt = exp_cnt + 16'd1;
            exp_pulses++;
        end else begin
            exp_err = 1'b1;
        end
        @(negedge clk);
        check("setup_fd", fd, exp_fd);
        check("setup_fs", 512'(fs), 512'd0);
        check("setup_busy", 512'(busy), 512'd1);
        check("setup_ready", 512'(ready), 512'd0);
        @(negedge clk);
        check("strobe_fs", 512'(fs), 512'(efs));
        check("strobe_fd", fd, exp_fd);
        @(negedge clk);
        check("hold_fs", 512'(fs), 512'd0);
        check("hold_fd", fd, exp_fd);
        check("hold_count", 512'(fw), 512'(exp_cnt));
        @(negedge clk);
        check("idle_busy", 512'(busy), 512'd0);
        check("idle_err", 512'(err), 512'(exp_err));
        check("pulse_total", 512'(pulses), 512'(exp_pulses));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [7:0] c;
        logic [7:0] f;
        rst        = 1'b1;
        valid      = 1'b0;
        word       = '0;
        exp_fd     = '0;
        exp_err    = 1'b0;
        exp_cnt    = '0;
        exp_pulses = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_fd", fd, 512'd0);
        check("rst_fs", 512'(fs), 512'd0);
        check("rst_err", 512'(err), 512'd0);
        check("rst_count", 512'(fw), 512'd0);
        check("rst_busy", 512'(busy), 512'd0);
        check("rst_ready", 512'(ready), 512'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single deterministic frame: column 2, frame 3 -> bit 43.
        send_packet(8'd2, 8'd3, 1'b1, 1'b0, 1'b0);
        check("single_count", 512'(fw), 512'd1);

        // Bad marker is dropped and flags an error.
        send_word(32'h1234_5678, 1'b0);
        exp_err = 1'b1;
        @(negedge clk);
        check("badmark_err", 512'(err), 512'd1);
        check("badmark_busy", 512'(busy), 512'd0);
        check("badmark_count", 512'(fw), 512'(exp_cnt));
        @(posedge clk);
        #1;
        send_packet(8'd1, 8'd5, 1'b0, 1'b0, 1'b0);

        // Out-of-range column and frame.
        send_packet(8'd10, 8'd0, 1'b0, 1'b0, 1'b0);
        send_packet(8'd0, 8'd20, 1'b0, 1'b1, 1'b0);
        // Corners of the strobe vector.
        send_packet(8'd9, 8'd19, 1'b0, 1'b1, 1'b0);
        send_packet(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a packet.
        send_word({8'hFA, 8'd4, 8'd4, 8'd0}, 1'b0);
        for (int r = 0; r < 7; r++) send_word(W'($urandom), 1'b0);
        check("mid_fd_stable", fd, exp_fd);
        #2;
        rst = 1'b1;
        #1;
        check("async_fd", fd, 512'd0);
        check("async_fs", 512'(fs), 512'd0);
        check("async_err", 512'(err), 512'd0);
        check("async_count", 512'(fw), 512'd0);
        check("async_busy", 512'(busy), 512'd0);
        exp_fd  = '0;
        exp_err = 1'b0;
        exp_cnt = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_packet(8'd3, 8'd7, 1'b1, 1'b0, 1'b0);

        // Randomized packets with random stalls, occasionally out of range.
        for (int i = 0; i < 10; i++) begin
            c = 8'($urandom_range(0, NC));
            f = 8'($urandom_range(0, MF));
            send_packet(c, f, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end

`ifdef CFG_FRAME_CHECKSUM_EN
        send_packet(8'd5, 8'd6, 1'b0, 1'b0, 1'b0);
        send_packet(8'd5, 8'd7, 1'b0, 1'b1, 1'b1);
        check("chk_err", 512'(err), 512'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
